// File: rtl/edge_highlighter.sv
// Rise/fall edge detector for a level signal, with an optional 2-flop
// synchronizer in front. Each output is a one-cycle registered pulse.
module edge_highlighter #(
   parameter int unsigned USE_SYNC = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_sig,
   output logic rise_pulse,
   output logic fall_pulse
);

   logic cur_c;
   logic prev_q;
   logic prev_d;
   logic rise_q;
   logic rise_d;
   logic fall_q;
   logic fall_d;

   generate
      if (USE_SYNC != 0) begin : g_sync
         (* ASYNC_REG = "TRUE" *) logic s1_q;
         (* ASYNC_REG = "TRUE" *) logic s2_q;

         // Two-flop synchronizer for an input that may be asynchronous to clk.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_q <= 1'b0;
               s2_q <= 1'b0;
            end else begin
               s1_q <= in_sig;
               s2_q <= s1_q;
            end
         end

         assign cur_c = s2_q;
      end else begin : g_direct
         assign cur_c = in_sig;
      end
   endgenerate

   // Compare the conditioned level with its previous-cycle value.
   always_comb begin
      prev_d = cur_c;
      rise_d = cur_c & ~prev_q;
      fall_d = ~cur_c & prev_q;
   end

   // History and output registers; reset clears history so a 1 held across
   // release is seen as a fresh rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule

// File: tb/tb_edge_highlighter.sv
// Directed bench for edge_highlighter (USE_SYNC=1) with a per-cycle
// reference model of the synchronizer/history/output pipeline.
module tb_edge_highlighter;

   logic clk;
   logic rst_n;
   logic in_sig;
   logic rise_pulse;
   logic fall_pulse;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   edge_highlighter #(.USE_SYNC(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_sig     (in_sig),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of the conditioned-input pipeline.
   logic m_s1, m_s2, m_prev, m_rise, m_fall;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 <= 1'b0; m_s2 <= 1'b0; m_prev <= 1'b0;
         m_rise <= 1'b0; m_fall <= 1'b0;
      end else begin
         m_s1   <= in_sig;
         m_s2   <= m_s1;
         m_prev <= m_s2;
         m_rise <= m_s2 & ~m_prev;
         m_fall <= ~m_s2 & m_prev;
      end
   end

   // Every-cycle comparison against the model; stops at the first mismatch.
   always @(negedge clk) begin
      if (mon_en) begin
         n_checks++;
         if (rise_pulse !== m_rise || fall_pulse !== m_fall ||
             (rise_pulse === 1'b1 && fall_pulse === 1'b1)) begin
            n_fail++;
            $display("FAIL model t=%0t rise=%b fall=%b expected rise=%b fall=%b",
                     $time, rise_pulse, fall_pulse, m_rise, m_fall);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
         end
      end
   end

   // Sample outputs at the falling edge, then apply the next input level.
   task automatic cyc(input logic v, output logic r, output logic f);
      @(negedge clk);
      r = rise_pulse;
      f = fall_pulse;
      in_sig = v;
   endtask

   task automatic test_reset();
      logic r, f;
      rst_n  = 1'b0;
      in_sig = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, r, f);
         n_checks++;
         if (r !== 1'b0 || f !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold i=%0d rise=%b fall=%b expected 0 0", i, r, f);
         end
      end
      rst_n  = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, r, f);
         n_checks++;
         if (r !== 1'b0 || f !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet i=%0d rise=%b fall=%b expected 0 0", i, r, f);
         end
      end
   endtask

   task automatic test_single_cycle();
      logic [15:0] stim  = 16'h0001;
      logic [15:0] exp_r = 16'h0008;
      logic [15:0] exp_f = 16'h0010;
      logic r, f;
      for (int k = 0; k < 16; k++) begin
         cyc(stim[k], r, f);
         n_checks++;
         if (r !== exp_r[k] || f !== exp_f[k]) begin
            n_fail++;
            $display("FAIL single k=%0d rise=%b fall=%b expected rise=%b fall=%b",
                     k, r, f, exp_r[k], exp_f[k]);
         end
      end
   endtask

   task automatic test_long_high();
      logic [15:0] stim  = 16'h001F;
      logic [15:0] exp_r = 16'h0008;
      logic [15:0] exp_f = 16'h0100;
      logic r, f;
      for (int k = 0; k < 16; k++) begin
         cyc(stim[k], r, f);
         n_checks++;
         if (r !== exp_r[k] || f !== exp_f[k]) begin
            n_fail++;
            $display("FAIL long_high k=%0d rise=%b fall=%b expected rise=%b fall=%b",
                     k, r, f, exp_r[k], exp_f[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] stim  = 16'h0033;
      logic [15:0] exp_r = 16'h0088;
      logic [15:0] exp_f = 16'h0220;
      logic r, f;
      for (int k = 0; k < 16; k++) begin
         cyc(stim[k], r, f);
         n_checks++;
         if (r !== exp_r[k] || f !== exp_f[k]) begin
            n_fail++;
            $display("FAIL back_to_back k=%0d rise=%b fall=%b expected rise=%b fall=%b",
                     k, r, f, exp_r[k], exp_f[k]);
         end
      end
   endtask

   task automatic test_toggle();
      logic [15:0] stim  = 16'h0555;
      logic [15:0] exp_r = 16'h2AA8;
      logic [15:0] exp_f = 16'h5550;
      logic r, f;
      for (int k = 0; k < 16; k++) begin
         cyc(stim[k], r, f);
         n_checks++;
         if (r !== exp_r[k] || f !== exp_f[k]) begin
            n_fail++;
            $display("FAIL toggle k=%0d rise=%b fall=%b expected rise=%b fall=%b",
                     k, r, f, exp_r[k], exp_f[k]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic [15:0] stim  = 16'h0387;
      logic [15:0] exp_r = 16'h0404;
      logic [15:0] exp_f = 16'h2040;
      logic r, f;
      for (int k = 0; k < 4; k++) cyc(1'b1, r, f);
      n_checks++;
      if (r !== 1'b1 || f !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_pre_rise rise=%b fall=%b expected 1 0", r, f);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_async_clear rise=%b fall=%b expected 0 0", rise_pulse, fall_pulse);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         cyc(stim[k], r, f);
         n_checks++;
         if (r !== exp_r[k] || f !== exp_f[k]) begin
            n_fail++;
            $display("FAIL mid_after k=%0d rise=%b fall=%b expected rise=%b fall=%b",
                     k, r, f, exp_r[k], exp_f[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_long_high();
      test_back_to_back();
      test_toggle();
      test_reset_midstream();
      @(negedge clk);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
